hazard_scoreboard: RTL

//   Producer side of the register-file read/write interface: tracks destination registers of
//   in-flight instructions in E, M and W and drives the register file's reg_write, write_addr,

---
 rtl/hazard_pkg.sv | 23 ++
 rtl/hazard_scoreboard_if.sv | 35 +++
 rtl/hazard_slot.sv | 38 +++
 rtl/hazard_scoreboard.sv | 113 +++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings and slot record for the hazard scoreboard.
// Slot field widths here set the register/Tnew widths used by every file.
package hazard_pkg;

    localparam int unsigned HZ_AW = 5;
    localparam int unsigned HZ_TW = 2;

    localparam logic [1:0] FWD_GRF = 2'd0;
    localparam logic [1:0] FWD_E   = 2'd1;
    localparam logic [1:0] FWD_M   = 2'd2;
    localparam logic [1:0] FWD_W   = 2'd3;

    // All-ones Tuse marks a source operand the instruction never reads.
    localparam logic [HZ_TW-1:0] TUSE_NONE = '1;

    typedef struct packed {
        logic             valid;
        logic             writes;
        logic [HZ_AW-1:0] dst;
        logic [HZ_TW-1:0] tnew;
    } slot_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-side bundle of the hazard scoreboard: D-stage fields in, stall/bypass/write-port out.
// d_valid qualifies the D fields; stall is the inverse of ready, so D is consumed on a clock edge where d_valid && !stall.
interface hazard_scoreboard_if #(
    parameter int unsigned AW = 5,
    parameter int unsigned TW = 2
);
    logic          d_valid;
    logic [AW-1:0] d_rs;
    logic [AW-1:0] d_rt;
    logic [TW-1:0] d_tuse_rs;
    logic [TW-1:0] d_tuse_rt;
    logic          d_writes;
    logic [AW-1:0] d_dst;
    logic [TW-1:0] d_tnew;

    logic          stall;
    logic [1:0]    fwd_rs_sel;
    logic [1:0]    fwd_rt_sel;
    logic          forward_rs_grf;
    logic          forward_rt_grf;
    logic          reg_write;
    logic [AW-1:0] write_addr;

    modport master (
        output d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_writes, d_dst, d_tnew,
        input  stall, fwd_rs_sel, fwd_rt_sel, forward_rs_grf, forward_rt_grf,
               reg_write, write_addr
    );

    modport slave (
        input  d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_writes, d_dst, d_tnew,
        output stall, fwd_rs_sel, fwd_rt_sel, forward_rs_grf, forward_rt_grf,
               reg_write, write_addr
    );
endinterface

// File: rtl/hazard_slot.sv
// One pipeline-stage slot {valid, writes, dst, tnew}: load-or-bubble mux, optional Tnew countdown.
// DECR=0 for the E slot (fresh Tnew from decode), DECR=1 for slots fed by an older stage.
module hazard_slot
    import hazard_pkg::*;
#(
    parameter bit DECR = 1'b1
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  load_i,
    input  slot_t slot_i,
    output slot_t slot_o
);

    slot_t slot_d;
    slot_t slot_q;

    always_comb begin
        slot_d = '0;
        if (load_i) begin
            slot_d = slot_i;
            if (DECR && (slot_i.tnew != '0)) begin
                slot_d.tnew = slot_i.tnew - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slot_o = slot_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Tuse/Tnew hazard scoreboard: tracks E/M/W destinations, drives D stall, bypass selects and GRF write port.
// Build option HAZARD_BYPASS_EN enables E/M bypass; without it only W write-through forwarding exists.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned AW = HZ_AW,
    parameter int unsigned TW = HZ_TW
) (
    input  logic                clk,
    input  logic                reset,
    hazard_scoreboard_if.slave  hz
);

    slot_t e_q;
    slot_t m_q;
    slot_t w_q;
    slot_t d_slot;
    logic  e_load;
    logic  stall_w;
    logic [2:0] rs_res;
    logic [2:0] rt_res;

    function automatic logic slot_match(input slot_t s, input logic [AW-1:0] r);
        return s.valid && s.writes && (s.dst == r) && (r != '0);
    endfunction

    // Result is {stall, sel}; only the youngest matching slot is examined.
    function automatic logic [2:0] resolve(input logic [AW-1:0] r, input logic [TW-1:0] tuse,
                                           input slot_t e, input slot_t m, input slot_t w);
        logic [2:0] res;
        slot_t      win;
        logic [1:0] code;
        logic       found;
        res   = '0;
        win   = '0;
        code  = FWD_GRF;
        found = 1'b1;
        if (slot_match(e, r)) begin
            win  = e;
            code = FWD_E;
        end else if (slot_match(m, r)) begin
            win  = m;
            code = FWD_M;
        end else if (slot_match(w, r)) begin
            win  = w;
            code = FWD_W;
        end else begin
            found = 1'b0;
        end
        if (found && (tuse != TUSE_NONE)) begin
`ifdef HAZARD_BYPASS_EN
            if (win.tnew > tuse) begin
                res[2] = 1'b1;
            end else if (win.tnew == '0) begin
                res[1:0] = code;
            end
`else
            if ((code != FWD_W) || (win.tnew > tuse)) begin
                res[2] = 1'b1;
            end else if (win.tnew == '0) begin
                res[1:0] = FWD_W;
            end
`endif
        end
        return res;
    endfunction

    always_comb begin
        d_slot        = '0;
        d_slot.valid  = 1'b1;
        d_slot.writes = hz.d_writes;
        d_slot.dst    = hz.d_dst;
        d_slot.tnew   = hz.d_tnew;
    end

    assign rs_res  = resolve(hz.d_rs, hz.d_tuse_rs, e_q, m_q, w_q);
    assign rt_res  = resolve(hz.d_rt, hz.d_tuse_rt, e_q, m_q, w_q);
    assign stall_w = hz.d_valid && (rs_res[2] || rt_res[2]);
    assign e_load  = hz.d_valid && !stall_w;

    hazard_slot #(.DECR(1'b0)) u_slot_e (
        .clk    (clk),
        .reset  (reset),
        .load_i (e_load),
        .slot_i (d_slot),
        .slot_o (e_q)
    );

    hazard_slot #(.DECR(1'b1)) u_slot_m (
        .clk    (clk),
        .reset  (reset),
        .load_i (1'b1),
        .slot_i (e_q),
        .slot_o (m_q)
    );

    hazard_slot #(.DECR(1'b1)) u_slot_w (
        .clk    (clk),
        .reset  (reset),
        .load_i (1'b1),
        .slot_i (m_q),
        .slot_o (w_q)
    );

    assign hz.stall          = stall_w;
    assign hz.fwd_rs_sel     = rs_res[1:0];
    assign hz.fwd_rt_sel     = rt_res[1:0];
    assign hz.forward_rs_grf = (rs_res[1:0] == FWD_W);
    assign hz.forward_rt_grf = (rt_res[1:0] == FWD_W);
    assign hz.reg_write      = w_q.valid && w_q.writes && (w_q.dst != '0);
    assign hz.write_addr     = w_q.dst;

endmodule
